ht_hazard_guard: RTL
====================

Name: ht_hazard_guard

Overview:
- Sits directly upstream of the hash-table top, between the lock-request front end and the hash-table command port.
- Holds back any command whose key matches a command still in flight inside the hash-table pipeline (calc_hash → head_table → data_table). This prevents read-modify-write hazards on the same bucket chain.
- Retires in-flight keys by snooping the hash-table result handshake. The pipeline returns results in command order.

Parameters:
- KEY_WIDTH, 32: key width; equals the hash_table package value.
- VALUE_WIDTH, 32: value width; equals the hash_table package value.
- MAX_INFLIGHT, 8: maximum commands outstanding in the hash table; power of two, ≥2.
- CNT_WIDTH, $clog2(MAX_INFLIGHT+1): width of the occupancy counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous reset, active low.
- in_valid  in  1  command valid from the front end.
- in_ready  out  1  command accepted.
- in_key  in  KEY_WIDTH  command key.
- in_value  in  VALUE_WIDTH  command value.
- in_opcode  in  2  command opcode (search/insert/delete, hash_table encoding).
- out_valid  out  1  to ht_cmd_if_valid.
- out_ready  in  1  from ht_cmd_if_ready.
- out_key  out  KEY_WIDTH  to ht_cmd_if_key.
- out_value  out  VALUE_WIDTH  to ht_cmd_if_value.
- out_opcode  out  2  to ht_cmd_if_opcode.
- res_valid  in  1  snoop of ht_res_if_valid.
- res_ready  in  1  snoop of ht_res_if_ready.
- inflight_cnt  out  CNT_WIDTH  current in-flight count.
- hazard_stall  out  1  high while the input is blocked by a key match.
- err_underflow  out  1  sticky; result retired with an empty table.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active low, sampled on the rising edge of clk_i.
- Reset values: out_valid=0, out_key/value/opcode=0, inflight_cnt=0, all table valid bits=0, wr_ptr=rd_ptr=0, err_underflow=0, hazard_stall=0.
  - Reset asserted mid-operation discards all in-flight state and any held output. Upstream must also be reset.
- In-flight table: circular FIFO of MAX_INFLIGHT entries, each {valid, key}, with wr_ptr/rd_ptr of $clog2(MAX_INFLIGHT) bits. Pointers wrap modulo MAX_INFLIGHT.
- Output stage: a single register.
  - out_fire = out_valid & out_ready.
  - slot_free = ~out_valid | out_ready.
- Combinational hazard check:
  - match = OR over entries of (valid[i] & key[i]==in_key), evaluated on the registered table state.
  - hazard_stall = in_valid & match.
  - full = (inflight_cnt == MAX_INFLIGHT).
- in_ready = slot_free & ~match & ~full. in_ready may depend on in_key; upstream must hold key stable while valid.
- Accept (in_valid & in_ready):
  - Load the output register.
  - Write {1, in_key} at wr_ptr; wr_ptr++.
  - Latency in→out: 1 cycle.
  - A key is tracked from accept, so an entry waiting in the output register also blocks duplicates.
- Retire (res_valid & res_ready):
  - If inflight_cnt > 0: clear valid[rd_ptr]; rd_ptr++.
  - If inflight_cnt == 0: no state change; set err_underflow (cleared only by reset).
- Counter:
  - +1 on accept, −1 on a legal retire.
  - Simultaneous accept and retire: count unchanged; both pointers advance.
- Same-cycle retire of the matching key does not unblock that cycle, because match uses pre-edge state. Acceptance occurs next cycle.
- Full: with all MAX_INFLIGHT entries occupied, in_ready=0 even with no match. A retire in the same cycle does not relieve full until the next cycle.
- Output handshake:
  - out_* are held stable while out_valid & ~out_ready.
  - out_valid drops after out_fire if no new accept occurs that cycle.
  - Back-to-back distinct keys sustain 1 command/cycle while out_ready=1.
- All opcodes, search included, are subject to the hazard check.

Decomposition:
- Shared package (hash_table): KEY_WIDTH, VALUE_WIDTH, opcode enum (OP_SEARCH/OP_INSERT/OP_DELETE), and a new typedef inflight_entry_t {logic valid; logic [KEY_WIDTH-1:0] key}.
- One sub-module: ht_key_cam. It holds the MAX_INFLIGHT-entry key array with write/clear ports and a combinational match output.
- ht_hazard_guard owns the pointers, counter, output register and handshake.

Test Plan:
- Reset, then in key=0x10, 0x20, 0x30 on consecutive cycles with out_ready=1 → outputs on cycles 1, 2, 3 in order; inflight_cnt=3; hazard_stall never asserts.
- Send insert key=0x55, then search key=0x55 → second held; hazard_stall=1. Pulse a res handshake → key 0x55 accepted on the cycle after the retire edge, not the same cycle.
- Send 8 distinct keys with no results, then a 9th → in_ready=0, inflight_cnt=8. One retire → 9th accepted the following cycle; wr_ptr wraps to 1.
- out_ready=0 for 4 cycles with key=0xA held in the output register → out_key stays 0xA, out_valid=1. A new input key=0xA is blocked; a new input key=0xB is blocked because the slot is busy.
- Simultaneous accept and retire every cycle for 20 cycles with rotating keys → inflight_cnt constant; pointers wrap; results match the FIFO order.
- res handshake with inflight_cnt=0 → err_underflow=1 and remains set; inflight_cnt stays 0. Assert rst_ni=0 mid-stream → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ht_hazard_guard_pkg.sv
// ht_hazard_guard_pkg: shared hash-table widths, opcode encoding and in-flight entry type
//   KEY_WIDTH / VALUE_WIDTH : hash-table key and value widths
//   op_e                    : command opcode encoding (search/insert/delete)
//   inflight_entry_t        : one tracked in-flight command {valid, key}
package ht_hazard_guard_pkg;

    localparam int unsigned KEY_WIDTH   = 32;
    localparam int unsigned VALUE_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2
    } op_e;

    typedef struct packed {
        logic                 valid;
        logic [KEY_WIDTH-1:0] key;
    } inflight_entry_t;

endpackage

// File: rtl/ht_hazard_guard_key_cam.sv
// ht_key_cam: small key array of in-flight commands with write/clear ports and a combinational match
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   wr_en/wr_idx/wr_key : mark entry wr_idx valid with wr_key
//   clr_en/clr_idx      : invalidate entry clr_idx
//   lookup_key          : key to compare against all valid entries
//   match               : some valid entry holds lookup_key (pre-edge state)
module ht_key_cam
    import ht_hazard_guard_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [KEY_WIDTH-1:0] wr_key,
    input  logic                 clr_en,
    input  logic [IW-1:0]        clr_idx,
    input  logic [KEY_WIDTH-1:0] lookup_key,
    output logic                 match
);

    inflight_entry_t r_tab [N];

    // A write and a clear never target the same live slot; write is ordered last anyway.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N); i++) r_tab[i] <= '0;
        end else begin
            if (clr_en) r_tab[clr_idx].valid <= 1'b0;
            if (wr_en) r_tab[wr_idx] <= '{valid: 1'b1, key: wr_key};
        end
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < int'(N); i++) match = match | (r_tab[i].valid & (r_tab[i].key == lookup_key));
    end

endmodule

// File: rtl/ht_hazard_guard.sv
// ht_hazard_guard: holds back hash-table commands whose key is still in flight in the pipeline
//   clk_i, rst_ni                     : clock, synchronous active-low reset
//   in_valid/in_ready/in_*            : command from the lock-request front end
//   out_valid/out_ready/out_*         : registered command to the hash-table command port
//   res_valid/res_ready               : snoop of the in-order result handshake, retires oldest key
//   inflight_cnt                      : commands accepted but not yet retired
//   hazard_stall                      : input blocked by a key match
//   err_underflow                     : sticky, a result was retired with nothing in flight
module ht_hazard_guard
    import ht_hazard_guard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [KEY_WIDTH-1:0]   in_key,
    input  logic [VALUE_WIDTH-1:0] in_value,
    input  logic [1:0]             in_opcode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [KEY_WIDTH-1:0]   out_key,
    output logic [VALUE_WIDTH-1:0] out_value,
    output logic [1:0]             out_opcode,
    input  logic                   res_valid,
    input  logic                   res_ready,
    output logic [CNT_WIDTH-1:0]   inflight_cnt,
    output logic                   hazard_stall,
    output logic                   err_underflow
);

    localparam int unsigned PW = $clog2(MAX_INFLIGHT);

    logic                   r_out_valid;
    logic [KEY_WIDTH-1:0]   r_out_key;
    logic [VALUE_WIDTH-1:0] r_out_value;
    logic [1:0]             r_out_opcode;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_err;

    logic w_match;
    logic w_slot_free;
    logic w_full;
    logic w_accept;
    logic w_retire;
    logic w_retire_ok;

    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_full      = r_cnt == CNT_WIDTH'(MAX_INFLIGHT);
    assign in_ready    = w_slot_free & ~w_match & ~w_full;
    assign w_accept    = in_valid & in_ready;
    assign w_retire    = res_valid & res_ready;
    assign w_retire_ok = w_retire & (r_cnt != '0);

    // Tracking starts at accept, so a command parked in the output register already blocks duplicates.
    ht_key_cam #(.N(MAX_INFLIGHT)) u_cam (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_en      (w_accept),
        .wr_idx     (r_wr_ptr),
        .wr_key     (in_key),
        .clr_en     (w_retire_ok),
        .clr_idx    (r_rd_ptr),
        .lookup_key (in_key),
        .match      (w_match)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_out_valid  <= 1'b0;
            r_out_key    <= '0;
            r_out_value  <= '0;
            r_out_opcode <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_key    <= in_key;
                r_out_value  <= in_value;
                r_out_opcode <= in_opcode;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
            r_wr_ptr <= w_accept ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_retire_ok ? r_rd_ptr + PW'(1) : r_rd_ptr;
            r_cnt    <= (w_accept & ~w_retire_ok) ? r_cnt + CNT_WIDTH'(1) :
                        (~w_accept & w_retire_ok) ? r_cnt - CNT_WIDTH'(1) : r_cnt;
            r_err    <= r_err | (w_retire & (r_cnt == '0));
        end
    end

    assign out_valid     = r_out_valid;
    assign out_key       = r_out_key;
    assign out_value     = r_out_value;
    assign out_opcode    = r_out_opcode;
    assign inflight_cnt  = r_cnt;
    assign hazard_stall  = in_valid & w_match;
    assign err_underflow = r_err;

endmodule
